// File: rtl/bicubic_pkg.sv
// -----------------------------------------------------------------------------
// bicubic_pkg
//   Shared constants and types for the bicubic interpolation datapath.
//   PIX_W      : width of one unsigned pixel sample.
//   DEF_LINE_W : default image line length (samples per row) used as the
//                vertical tap spacing of the row tap buffer.
//   pix_t      : one pixel sample.
// -----------------------------------------------------------------------------
package bicubic_pkg;

  localparam int PIX_W      = 15;
  localparam int DEF_LINE_W = 4;

  typedef logic [PIX_W-1:0] pix_t;

endpackage : bicubic_pkg

// File: rtl/line_delay.sv
// -----------------------------------------------------------------------------
// line_delay
//   Enable-gated delay line, DEPTH entries deep. Every cycle with en=1 the
//   line shifts by one: din enters entry 0 and the oldest entry falls off the
//   end. With en=0 nothing moves, so the delay is counted in enabled cycles,
//   not clock cycles. dout is the oldest entry, i.e. the value that entered
//   DEPTH enables ago. rst clears every entry asynchronously.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high clear of all entries
//     en   : shift enable
//     din  : sample entering the line
//     dout : sample leaving the line (registered)
// -----------------------------------------------------------------------------
module line_delay #(
  parameter int DATA_W = 15,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] taps_q [DEPTH];
  logic [DATA_W-1:0] taps_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      taps_d[i] = taps_q[i];
    end
    if (en) begin
      taps_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        taps_q[i] <= taps_d[i];
      end
    end
  end

  assign dout = taps_q[DEPTH-1];

endmodule : line_delay

// File: rtl/bicubic_row_tap_buffer.sv
// -----------------------------------------------------------------------------
// bicubic_row_tap_buffer
//   Input line-buffer stage of the bicubic interpolator. Turns a raster stream
//   of pixel samples into four vertically aligned samples (rows n..n-3) for
//   the 4x4 neighbourhood coefficient stage.
//
//   Handshake: act is a one-sided accept strobe with no back-pressure. A sample
//   on `in` is taken on every rising edge where act=1 and rst=0; when act=0
//   the whole buffer holds and `in` is ignored. There is no output valid flag:
//   downstream counts acceptances to know when the taps hold real history
//   (taps without history read back the reset zeros).
//
//   Ports:
//     clk   : rising-edge clock, sole domain
//     rst   : asynchronous active-high reset, clears all history, wins over act
//     act   : sample accept / shift enable
//     in    : incoming pixel sample
//     out_0 : most recently accepted sample           (row n)
//     out_1 : sample LINE_W acceptances before out_0   (row n-1)
//     out_2 : sample 2*LINE_W acceptances before out_0 (row n-2)
//     out_3 : sample 3*LINE_W acceptances before out_0 (row n-3)
//
//   All outputs come straight from flops; no combinational path from in/act.
// -----------------------------------------------------------------------------
module bicubic_row_tap_buffer
  import bicubic_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int LINE_W = DEF_LINE_W   // legal 2..1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              act,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3
);

  // Row n tap register; the three line delays hang off it.
  logic [DATA_W-1:0] out_0_q;
  logic [DATA_W-1:0] out_0_d;

  logic [DATA_W-1:0] tap_1;
  logic [DATA_W-1:0] tap_2;
  logic [DATA_W-1:0] tap_3;

  always_comb begin
    out_0_d = out_0_q;
    if (act) begin
      out_0_d = in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_0_q <= '0;
    end else begin
      out_0_q <= out_0_d;
    end
  end

  // Each line delay takes the *current* content of the tap above it, so on an
  // accepting edge the previous row-n sample moves into the first line while
  // the new sample lands in out_0_q. That keeps out_1 exactly LINE_W
  // acceptances behind out_0 (total chain 3*LINE_W+1 entries).
  line_delay #(
    .DATA_W (DATA_W),
    .DEPTH  (LINE_W)
  ) u_line_1 (
    .clk  (clk),
    .rst  (rst),
    .en   (act),
    .din  (out_0_q),
    .dout (tap_1)
  );

  line_delay #(
    .DATA_W (DATA_W),
    .DEPTH  (LINE_W)
  ) u_line_2 (
    .clk  (clk),
    .rst  (rst),
    .en   (act),
    .din  (tap_1),
    .dout (tap_2)
  );

  line_delay #(
    .DATA_W (DATA_W),
    .DEPTH  (LINE_W)
  ) u_line_3 (
    .clk  (clk),
    .rst  (rst),
    .en   (act),
    .din  (tap_2),
    .dout (tap_3)
  );

  assign out_0 = out_0_q;
  assign out_1 = tap_1;
  assign out_2 = tap_2;
  assign out_3 = tap_3;

endmodule : bicubic_row_tap_buffer

// File: tb/tb_bicubic_row_tap_buffer.sv
module tb_bicubic_row_tap_buffer;
  import bicubic_pkg::*;

  localparam int DW = PIX_W;
  localparam int LW = 4;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst;
  logic          act;
  logic [DW-1:0] in_s;
  logic [DW-1:0] out_0, out_1, out_2, out_3;

  always #5 clk = ~clk;

  bicubic_row_tap_buffer #(
    .DATA_W (DW),
    .LINE_W (LW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .act   (act),
    .in    (in_s),
    .out_0 (out_0),
    .out_1 (out_1),
    .out_2 (out_2),
    .out_3 (out_3)
  );

  // ---------------------------------------------------------------- scoreboard
  // exp_q holds the accepted samples since the last reset, newest at the back.
  // Tap k must show the sample accepted k*LW acceptances before the newest,
  // or 0 if there is not that much history.
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_tap(input int k);
    int back;
    back = k * LW;
    if (exp_q.size() > back) return exp_q[exp_q.size() - 1 - back];
    return '0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".out_0"}, out_0, model_tap(0));
    check({tag, ".out_1"}, out_1, model_tap(1));
    check({tag, ".out_2"}, out_2, model_tap(2));
    check({tag, ".out_3"}, out_3, model_tap(3));
  endtask

  task automatic check_const(input string tag, input logic [DW-1:0] e0,
                             input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                             input logic [DW-1:0] e3);
    check({tag, ".out_0"}, out_0, e0);
    check({tag, ".out_1"}, out_1, e1);
    check({tag, ".out_2"}, out_2, e2);
    check({tag, ".out_3"}, out_3, e3);
  endtask

  // ---------------------------------------------------------------- drivers
  // One clock: drive inputs, take the edge, update the model, check #1 later.
  task automatic step(input string tag, input logic a, input logic [DW-1:0] d);
    act  = a;
    in_s = d;
    @(posedge clk);
    if (!rst && a) begin
      exp_q.push_back(d);
      if (exp_q.size() > 3 * LW + 1) void'(exp_q.pop_front());
    end
    #1;
    check_all(tag);
  endtask

  // Assert rst between edges and check the outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_const(tag, '0, '0, '0, '0);
  endtask

  task automatic release_reset();
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // 1. reset with act=1, in=2
    rst  = 1'b1;
    act  = 1'b1;
    in_s = DW'(2);
    #1;
    check_const("reset_init", '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, DW'(2));
    release_reset();

    // 2. fill 1..20
    for (int k = 1; k <= 20; k++) step("fill", 1'b1, DW'(k));
    check_const("fill_end", DW'(20), DW'(16), DW'(12), DW'(8));

    // 3. hold with changing in
    for (int k = 21; k <= 30; k++) step("hold", 1'b0, DW'(k));
    check_const("hold_end", DW'(20), DW'(16), DW'(12), DW'(8));

    // 4. async reset mid-stream, then refill 31..40
    async_reset("mid_rst");
    release_reset();
    for (int k = 31; k <= 40; k++) step("refill", 1'b1, DW'(k));
    check_const("refill_end", DW'(40), DW'(36), DW'(32), DW'(0));

    // 5. stall continuity
    async_reset("stall_rst");
    release_reset();
    for (int k = 31; k <= 34; k++) step("stall_a", 1'b1, DW'(k));
    for (int k = 41; k <= 50; k++) step("stall_hold", 1'b0, DW'(k));
    for (int k = 35; k <= 42; k++) step("stall_b", 1'b1, DW'(k));
    check_const("stall_end", DW'(42), DW'(38), DW'(34), DW'(0));

    // 6. reset wins over act
    async_reset("prio_rst");
    for (int i = 0; i < 5; i++) step("prio", 1'b1, DW'(100 + i));
    check_const("prio_end", '0, '0, '0, '0);
    release_reset();

    // randomized stream: bursty act, random data, occasional async reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rand_rst");
        release_reset();
      end
      step("rand", logic'($urandom_range(0, 3) != 0),
           DW'($urandom_range(0, (1 << DW) - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bicubic_row_tap_buffer
